// File: rtl/axi_master_read_pkg.sv
// Shared types and AXI constants for the read-channel master.
// Imported by the interface, the buffer and the top.
package axi_master_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axi_master_read_if.sv
// AXI4 read address and read data channels.
// Master drives AR and RREADY; slave drives ARREADY and R.
interface axi_master_read_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) ();

    logic [ID_W-1:0]   ARID;
    logic [ADDR_W-1:0] ARADDR;
    logic [LEN_W-1:0]  ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;
    logic              ARVALID;
    logic              ARREADY;

    logic [ID_W-1:0]   RID;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );

endinterface

// File: rtl/axi_master_read_rd_fifo2.sv
// Two-entry FIFO holding accepted R beats until the core pops them.
// Push when full and pop when empty are ignored.
module rd_fifo2 #(
    parameter int WIDTH = 33
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_cnt;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_cnt == 2'd2);
    assign empty  = (r_cnt == 2'd0);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign dout   = r_mem[r_rptr];

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_cnt  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 2'd1;
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - 2'd1;
            end
        end
    end

endmodule

// File: rtl/axi_master_read.sv
// AXI4 read master: one core request -> one AR burst, R beats
// collected in a 2-entry buffer for the core.
module axi_master_read
    import axi_master_pkg::*;
#(
    parameter int              ID_W      = 4,
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 32,
    parameter int              LEN_W     = 4,
    parameter logic [ID_W-1:0] MASTER_ID = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    axi_master_read_if.master axi,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    input  logic              rd_ready,
    output logic              busy,
    output logic              err,
    input  logic              err_clr
);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_araddr;
    logic [LEN_W-1:0]  r_arlen;
    logic [LEN_W-1:0]  r_cnt;
    logic              r_arvalid;
    logic              r_err;

    logic              w_req;
    logic              w_arhs;
    logic              w_rhs;
    logic              w_rready;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_err_set;
    logic [DATA_W:0]   w_dout;

    assign w_req    = req_valid && req_ready;
    assign w_arhs   = r_arvalid && axi.ARREADY;
    // RREADY depends only on state and buffer occupancy
    assign w_rready = (r_state == DATA) && !w_full;
    assign w_rhs    = axi.RVALID && w_rready;
    assign w_pop    = rd_valid && rd_ready;

    assign w_err_set = w_rhs && (
        (axi.RRESP != RESP_OKAY) ||
        (axi.RID != MASTER_ID) ||
        (axi.RLAST && (r_cnt < r_arlen)) ||
        (!axi.RLAST && (r_cnt >= r_arlen)));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        unique case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next = ADDR;
                end
            end
            ADDR: begin
                if (w_arhs) begin
                    w_next = DATA;
                end
            end
            DATA: begin
                if (w_rhs && axi.RLAST) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_arvalid <= 1'b0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_req) begin
                r_araddr  <= req_addr;
                r_arlen   <= req_len;
                r_arvalid <= 1'b1;
            end else if (w_arhs) begin
                r_arvalid <= 1'b0;
            end
            // counter saturates so overlong bursts cannot wrap
            if (w_arhs) begin
                r_cnt <= '0;
            end else if (w_rhs && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    rd_fifo2 #(
        .WIDTH(DATA_W + 1)
    ) u_buf (
        .clock (clock),
        .reset (reset),
        .push  (w_rhs),
        .pop   (w_pop),
        .din   ({axi.RDATA, axi.RLAST}),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    assign axi.ARID    = MASTER_ID;
    assign axi.ARADDR  = r_araddr;
    assign axi.ARLEN   = r_arlen;
    assign axi.ARSIZE  = SIZE_4B;
    assign axi.ARBURST = BURST_INCR;
    assign axi.ARVALID = r_arvalid;
    assign axi.RREADY  = w_rready;

    assign rd_valid = !w_empty;
    assign rd_data  = w_dout[DATA_W:1];
    assign rd_last  = w_dout[0];
    assign busy     = (r_state != IDLE);
    assign err      = r_err;

endmodule

// File: doc/axi_master_read.md
Name: axi_master_read

Overview:
- AXI4 read-channel master. Converts a single-request core-side read (address plus burst length) into one AR transaction, then collects the R beats into a 2-entry buffer.
- Drives the read channels that the interconnect routes to the SRAM slave read handler. It is the upstream producer of ARVALID/ARADDR/ARLEN and the consumer of RDATA/RLAST.
- Instantiated once per CPU port: instruction and data.

Parameters:
ID_W, 4, width of ARID/RID on the master side of the interconnect
ADDR_W, 32, address width
DATA_W, 32, data width; beat size fixed at 4 bytes
LEN_W, 4, ARLEN width; bursts of 1..16 beats
MASTER_ID, 0, constant driven on ARID and expected on RID

Ports:
clock  in  1  single clock, all logic on posedge
reset  in  1  synchronous, active-high reset
req_valid  in  1  core read request
req_ready  out  1  request accepted when valid&&ready
req_addr  in  ADDR_W  start byte address, word aligned
req_len  in  LEN_W  beats minus one
ARID  out  ID_W  = MASTER_ID
ARADDR  out  ADDR_W  burst start address
ARLEN  out  LEN_W  burst length minus one
ARSIZE  out  3  fixed 3'b010
ARBURST  out  2  fixed INCR 2'b01
ARVALID  out  1  address valid
ARREADY  in  1  address accepted
RID  in  ID_W  response ID
RDATA  in  DATA_W  read data
RRESP  in  2  response code
RLAST  in  1  last beat
RVALID  in  1  beat valid
RREADY  out  1  beat accepted when RVALID&&RREADY
rd_valid  out  1  buffered beat available to core
rd_data  out  DATA_W  buffered beat data
rd_last  out  1  buffered beat is last of burst
rd_ready  in  1  core pops head beat
busy  out  1  state != IDLE
err  out  1  sticky error flag
err_clr  in  1  clears err

Behaviour:
- Reset (synchronous, high on a clock edge):
  - state=IDLE; ARVALID=0; RREADY=0; buffer emptied so rd_valid=0; err=0; beat counter=0.
  - AR field registers go to 0. ARSIZE and ARBURST stay constant.
  - Reset mid-burst abandons the transaction immediately, with no drain.
- States: IDLE, ADDR, DATA.
- IDLE:
  - req_ready=1, combinational on state only.
  - On req_valid: latch req_addr into ARADDR and req_len into ARLEN, then go to ADDR.
  - The request is accepted even if the buffer still holds beats.
- ADDR:
  - ARVALID=1, a registered output.
  - ARADDR/ARLEN/ARID stay stable until ARREADY.
  - On ARVALID&&ARREADY: go to DATA and set beat counter=0. Minimum AR latency is 1 cycle after acceptance.
  - ARVALID never deasserts before ARREADY.
- DATA:
  - RREADY = !buffer_full, combinational from buffer occupancy only; no path from RVALID.
  - On RVALID&&RREADY:
    - push {RDATA, RLAST} and increment the beat counter;
    - set err if RRESP != OKAY (2'b00) or RID != MASTER_ID.
  - RLAST accepted with counter==ARLEN: go to IDLE.
  - Early RLAST (counter<ARLEN): set err, go to IDLE.
  - Late RLAST: a beat with counter==ARLEN and RLAST=0 sets err. Keep accepting beats until RLAST, then go to IDLE. The counter saturates at max.
- Buffer:
  - 2-entry FIFO. rd_valid = !empty. Pop on rd_valid&&rd_ready.
  - Push and pop in the same cycle are allowed at any occupancy where the push is permitted, and leave occupancy unchanged.
  - Full blocks the push because RREADY=0.
  - Data is visible on rd_data the cycle after the R handshake (1-cycle latency).
- err:
  - A set event has priority over err_clr in the same cycle.
- busy = (state != IDLE). Buffered beats do not count toward busy.

Decomposition:
- Package axi_master_pkg:
  - state enum {IDLE, ADDR, DATA};
  - constants SIZE_4B=3'b010, BURST_INCR=2'b01, RESP_OKAY=2'b00.
- Sub-module rd_fifo2:
  - parameterised WIDTH, 2 entries;
  - ports: push, pop, din, dout, full, empty.
- The FSM and counters stay in axi_master_read.

Test Plan:
- Single beat:
  - Stimulus: req addr=0x0000_0100, len=0; slave ARREADY=1 at once; RVALID with RDATA=0xDEAD_BEEF, RLAST=1; rd_ready=1.
  - Response: ARADDR=0x100, ARLEN=0, ARSIZE=2, ARBURST=1. rd_data=0xDEAD_BEEF and rd_last=1 one cycle after the R handshake. busy drops the cycle after RLAST is accepted.
- AR stall:
  - Stimulus: ARREADY held low 5 cycles.
  - Response: ARVALID stays 1 and ARADDR/ARLEN stay constant all 5 cycles. Exactly one AR handshake.
- Backpressure:
  - Stimulus: len=3, rd_ready=0 throughout the burst.
  - Response: after 2 beats RREADY=0 and occupancy stays 2. Raising rd_ready pops beats in order 0..3 with rd_last only on beat 3. No beat is lost or duplicated.
- Errors:
  - Stimulus: RRESP=2'b10 on beat 1 of 2; then err_clr pulsed; later RLAST on beat 0 of a len=2 burst.
  - Response: err=1 after the bad beat and stays set; err=0 after err_clr; err=1 again on the early RLAST, with state back to IDLE.
- Simultaneous push/pop:
  - Stimulus: len=7, RVALID and rd_ready held 1.
  - Response: RREADY stays 1 every cycle. 8 beats are delivered in 8 consecutive cycles after a 1-cycle latency.
- Reset mid-burst:
  - Stimulus: reset asserted after beat 2 of len=5.
  - Response: next cycle RREADY=0, ARVALID=0, rd_valid=0, busy=0, err=0.
